// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch queue: sequential word fetch with one outstanding request, DEPTH-entry FIFO, redirect flush.
// Optional misaligned-redirect trap enabled by defining IFQ_ALIGN_CHECK_EN.
module instr_prefetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic                     mem_req,
    output logic [31:0]              mem_addr,
    input  logic                     mem_gnt,
    input  logic                     mem_rvalid,
    input  logic [31:0]              mem_rdata,
    output logic                     instr_valid,
    output logic [31:0]              instr_data,
    output logic [31:0]              instr_pc,
    input  logic                     instr_ready,
    input  logic                     redirect,
    input  logic [31:0]              redirect_pc,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     misalign_err
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DISCARD} state_t;

    state_t        r_state, w_state_next;
    logic [31:0]   r_fetch_pc, w_fetch_next;
    logic [31:0]   r_mem_addr;
    logic          r_mem_req;
    logic          r_flush_pend;
    logic          r_park, w_park_next;
    logic [31:0]   r_data [DEPTH];
    logic [31:0]   r_pc   [DEPTH];
    logic [AW-1:0] r_wptr, r_rptr;
    logic [CW-1:0] r_count;
    logic          w_push, w_pop, w_misaligned, w_redir_ok;
    logic [31:0]   w_redir_pc;
    logic [CW:0]   w_occ_after;

`ifdef IFQ_ALIGN_CHECK_EN
    logic r_misalign;
    assign w_redir_pc   = redirect_pc;
    assign misalign_err = r_misalign;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_misalign <= 1'b0;
        else if (w_misaligned) r_misalign <= 1'b1;
    end
`else
    assign w_redir_pc   = redirect_pc & ~32'h3;
    assign misalign_err = 1'b0;
`endif

    assign w_misaligned = redirect && (w_redir_pc[1:0] != 2'b00);

    always_comb begin
        w_redir_ok   = redirect && !w_misaligned;
        w_park_next  = redirect ? w_misaligned : r_park;
        w_pop        = instr_ready && (r_count != '0) && !redirect;
        w_push       = (r_state == WAIT) && mem_rvalid && !redirect;
        w_occ_after  = {1'b0, r_count} + (CW+1)'(w_push) - (CW+1)'(w_pop);
        w_state_next = r_state;
        w_fetch_next = w_redir_ok ? w_redir_pc : r_fetch_pc;
        case (r_state)
            IDLE: begin
                if (!w_park_next && (redirect || (r_count < FULL)))
                    w_state_next = REQ;
            end
            REQ: begin
                // A granted request flushed by redirect still owes a response that must be drained.
                if (mem_gnt) begin
                    if (redirect || r_flush_pend) begin
                        w_state_next = DISCARD;
                    end else begin
                        w_state_next = WAIT;
                        w_fetch_next = r_fetch_pc + 32'd4;
                    end
                end
            end
            WAIT: begin
                if (mem_rvalid) begin
                    if (redirect) w_state_next = w_park_next ? IDLE : REQ;
                    else          w_state_next = (w_occ_after < {1'b0, FULL}) ? REQ : IDLE;
                end else if (redirect) begin
                    w_state_next = DISCARD;
                end
            end
            DISCARD: begin
                if (mem_rvalid) w_state_next = w_park_next ? IDLE : REQ;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_fetch_pc   <= RESET_PC;
            r_mem_addr   <= RESET_PC;
            r_mem_req    <= 1'b0;
            r_flush_pend <= 1'b0;
            r_park       <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_fetch_pc   <= w_fetch_next;
            r_mem_req    <= (w_state_next == REQ);
            r_flush_pend <= (r_state == REQ) && (w_state_next == REQ) && (r_flush_pend || redirect);
            r_park       <= w_park_next;
            if ((w_state_next == REQ) && (r_state != REQ))
                r_mem_addr <= w_fetch_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_data[i] <= '0;
                r_pc[i]   <= '0;
            end
        end else if (redirect) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_data[r_wptr] <= mem_rdata;
                r_pc[r_wptr]   <= r_mem_addr;
                r_wptr         <= r_wptr + AW'(1);
            end
            if (w_pop) r_rptr <= r_rptr + AW'(1);
            r_count <= w_occ_after[CW-1:0];
        end
    end

    assign mem_req     = r_mem_req;
    assign mem_addr    = r_mem_addr;
    assign count       = r_count;
    assign instr_valid = (r_count != '0);
    assign instr_data  = r_data[r_rptr];
    assign instr_pc    = r_pc[r_rptr];

endmodule
